i2c_slave_regfile: RTL

- Downstream partner of the APB-attached I2C master: an I2C target device with a small register file.
- Oversamples SCL/SDA on the system clock, detects START and STOP, matches a 7-bit address, and ACKs.
- Supports pointer-based writes and sequential reads.
- Serves as the on-chip bus partner for exercising the master end to end, and as a reusable peripheral.

---
 rtl/i2c_slave_regfile.sv | 280 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_slave_regfile.sv
// rtl/i2c_slave_regfile.sv - I2C target with a pointer-addressed 8-bit register file
// Optional I2C_SLAVE_GLITCH_FILTER_EN adds a 3-sample majority filter on SCL/SDA.
`timescale 1ns/1ps

module i2c_slave_regfile #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         DEPTH      = 16,
  localparam int        PTR_W      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             scl_in,
  input  logic             sda_in,
  output logic             sda_oe,
  output logic             busy,
  output logic             wr_strobe,
  output logic [PTR_W-1:0] wr_addr,
  output logic [7:0]       wr_data
);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WR_PTR,
    ST_WR_BYTE,
    ST_WR_ACK,
    ST_RD_BYTE,
    ST_RD_ACK,
    ST_WAIT_STOP
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic             r_scl_s1, r_scl_s2, r_sda_s1, r_sda_s2;
  logic             r_scl_prev, r_sda_prev;
  logic             w_scl, w_sda;
  logic             w_scl_rise, w_scl_fall, w_start, w_stop;

  logic [7:0]       r_shift;
  logic [2:0]       r_bit_cnt;
  logic             r_byte_full;
  logic [PTR_W-1:0] r_ptr;
  logic [7:0]       r_regs [DEPTH];
  logic             r_sda_oe;
  logic             r_busy;
  logic             r_wr_strobe;
  logic [PTR_W-1:0] r_wr_addr;
  logic [7:0]       r_wr_data;

  logic [7:0]       w_byte_in;
  logic             w_addr_match;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scl_s1 <= 1'b1;
      r_scl_s2 <= 1'b1;
      r_sda_s1 <= 1'b1;
      r_sda_s2 <= 1'b1;
    end else begin
      r_scl_s1 <= scl_in;
      r_scl_s2 <= r_scl_s1;
      r_sda_s1 <= sda_in;
      r_sda_s2 <= r_sda_s1;
    end
  end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  logic [1:0] r_scl_hist, r_sda_hist;
  logic       r_scl_filt, r_sda_filt;

  // Majority of the current and two previous samples, registered: single-clk pulses never win.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scl_hist <= 2'b11;
      r_sda_hist <= 2'b11;
      r_scl_filt <= 1'b1;
      r_sda_filt <= 1'b1;
    end else begin
      r_scl_hist <= {r_scl_hist[0], r_scl_s2};
      r_sda_hist <= {r_sda_hist[0], r_sda_s2};
      r_scl_filt <= (r_scl_s2 & r_scl_hist[0]) | (r_scl_s2 & r_scl_hist[1]) |
                    (r_scl_hist[0] & r_scl_hist[1]);
      r_sda_filt <= (r_sda_s2 & r_sda_hist[0]) | (r_sda_s2 & r_sda_hist[1]) |
                    (r_sda_hist[0] & r_sda_hist[1]);
    end
  end

  assign w_scl = r_scl_filt;
  assign w_sda = r_sda_filt;
`else
  assign w_scl = r_scl_s2;
  assign w_sda = r_sda_s2;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scl_prev <= 1'b1;
      r_sda_prev <= 1'b1;
    end else begin
      r_scl_prev <= w_scl;
      r_sda_prev <= w_sda;
    end
  end

  assign w_scl_rise   = w_scl & ~r_scl_prev;
  assign w_scl_fall   = ~w_scl & r_scl_prev;
  assign w_start      = w_scl & r_scl_prev & r_sda_prev & ~w_sda;
  assign w_stop       = w_scl & r_scl_prev & ~r_sda_prev & w_sda;
  assign w_byte_in    = {r_shift[6:0], w_sda};
  assign w_addr_match = (r_shift[7:1] == SLAVE_ADDR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_start) begin
      w_state_nxt = ST_ADDR;
    end else if (w_stop) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_ADDR: begin
          if (w_scl_fall && r_byte_full) begin
            w_state_nxt = w_addr_match ? ST_ADDR_ACK : ST_WAIT_STOP;
          end
        end
        ST_ADDR_ACK: begin
          if (w_scl_fall) begin
            w_state_nxt = r_shift[0] ? ST_RD_BYTE : ST_WR_PTR;
          end
        end
        ST_WR_PTR, ST_WR_BYTE: begin
          if (w_scl_fall && r_byte_full) begin
            w_state_nxt = ST_WR_ACK;
          end
        end
        ST_WR_ACK: begin
          if (w_scl_fall) begin
            w_state_nxt = ST_WR_BYTE;
          end
        end
        ST_RD_BYTE: begin
          if (w_scl_fall && r_byte_full) begin
            w_state_nxt = ST_RD_ACK;
          end
        end
        ST_RD_ACK: begin
          if (w_scl_rise && w_sda) begin
            w_state_nxt = ST_WAIT_STOP;
          end else if (w_scl_fall && r_byte_full) begin
            w_state_nxt = ST_RD_BYTE;
          end
        end
        default: w_state_nxt = r_state;
      endcase
    end
  end

  // r_byte_full marks "8th rise seen" (or master ACK seen); the matching scl_fall acts on it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift     <= 8'h00;
      r_bit_cnt   <= 3'd0;
      r_byte_full <= 1'b0;
      r_ptr       <= '0;
      r_sda_oe    <= 1'b0;
      r_busy      <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= 8'h00;
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= 8'h00;
      end
    end else begin
      r_wr_strobe <= 1'b0;
      if (w_start) begin
        r_busy      <= 1'b1;
        r_sda_oe    <= 1'b0;
        r_bit_cnt   <= 3'd0;
        r_byte_full <= 1'b0;
      end else if (w_stop) begin
        r_busy      <= 1'b0;
        r_sda_oe    <= 1'b0;
        r_bit_cnt   <= 3'd0;
        r_byte_full <= 1'b0;
      end else begin
        case (r_state)
          ST_ADDR, ST_WR_PTR, ST_WR_BYTE: begin
            if (w_scl_rise) begin
              r_shift   <= w_byte_in;
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                r_byte_full <= 1'b1;
                if (r_state == ST_WR_PTR) begin
                  r_ptr <= w_byte_in[PTR_W-1:0];
                end
                if (r_state == ST_WR_BYTE) begin
                  r_regs[r_ptr] <= w_byte_in;
                  r_wr_strobe   <= 1'b1;
                  r_wr_addr     <= r_ptr;
                  r_wr_data     <= w_byte_in;
                  r_ptr         <= r_ptr + PTR_W'(1);
                end
              end
            end else if (w_scl_fall && r_byte_full) begin
              r_byte_full <= 1'b0;
              r_sda_oe    <= (r_state != ST_ADDR) || w_addr_match;
            end
          end
          ST_ADDR_ACK: begin
            if (w_scl_fall) begin
              r_bit_cnt   <= 3'd0;
              r_byte_full <= 1'b0;
              if (r_shift[0]) begin
                r_shift  <= r_regs[r_ptr];
                r_sda_oe <= ~r_regs[r_ptr][7];
              end else begin
                r_sda_oe <= 1'b0;
              end
            end
          end
          ST_WR_ACK: begin
            if (w_scl_fall) begin
              r_sda_oe  <= 1'b0;
              r_bit_cnt <= 3'd0;
            end
          end
          ST_RD_BYTE: begin
            if (w_scl_rise) begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                r_byte_full <= 1'b1;
              end
            end else if (w_scl_fall) begin
              if (r_byte_full) begin
                r_byte_full <= 1'b0;
                r_sda_oe    <= 1'b0;
                r_ptr       <= r_ptr + PTR_W'(1);
              end else begin
                r_shift  <= {r_shift[6:0], 1'b0};
                r_sda_oe <= ~r_shift[6];
              end
            end
          end
          ST_RD_ACK: begin
            if (w_scl_rise && !w_sda) begin
              r_byte_full <= 1'b1;
            end else if (w_scl_fall && r_byte_full) begin
              r_byte_full <= 1'b0;
              r_bit_cnt   <= 3'd0;
              r_shift     <= r_regs[r_ptr];
              r_sda_oe    <= ~r_regs[r_ptr][7];
            end
          end
          ST_WAIT_STOP: begin
            r_sda_oe <= 1'b0;
          end
          default: begin
            r_sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

  assign sda_oe    = r_sda_oe;
  assign busy      = r_busy;
  assign wr_strobe = r_wr_strobe;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;

endmodule
